// File: rtl/tlb_ctrl_pkg.sv
// Shared types and constants for the CP0 TLB register block.
package tlb_ctrl_pkg;

  typedef enum logic [1:0] {
    TLBP  = 2'd0,
    TLBR  = 2'd1,
    TLBWI = 2'd2,
    TLBWR = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } tlb_state_e;

  // CP0 register numbers
  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  // Software-writable bit masks; bits outside a mask are read-only
  localparam logic [31:0] ENTRYLO_WMASK  = 32'h3FFF_FFFF;
  localparam logic [31:0] CONTEXT_WMASK  = 32'hFF80_0000;
  localparam logic [31:0] PAGEMASK_WMASK = 32'h1FFF_E000;
  localparam logic [31:0] ENTRYHI_WMASK  = 32'hFFFF_E0FF;
  localparam logic [31:0] INDEX_P_BIT    = 32'h8000_0000;

  // Mask with the low w bits set (Index / Wired field width)
  function automatic logic [31:0] low_mask(input int unsigned w);
    return (32'h1 << w) - 32'h1;
  endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// Wired register and the free-running Random replacement counter.
module tlb_random_ctr
  import tlb_ctrl_pkg::*;
#(
  parameter int TLB_LINE  = 32,
  parameter int TLB_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wired_we,
  input  logic [TLB_WIDTH-1:0] wired_wdata,
  output logic [TLB_WIDTH-1:0] random,
  output logic [TLB_WIDTH-1:0] wired
);

  localparam logic [TLB_WIDTH-1:0] TOP = TLB_WIDTH'(TLB_LINE - 1);

  logic [TLB_WIDTH-1:0] random_q, random_d;
  logic [TLB_WIDTH-1:0] wired_q, wired_d;

  // Random counts down from TOP to Wired, then wraps; a Wired write restarts it
  always_comb begin
    wired_d = wired_we ? wired_wdata : wired_q;
    if (wired_we)                random_d = TOP;
    else if (wired_q >= TOP)     random_d = TOP;
    else if (random_q == wired_q) random_d = TOP;
    else                         random_d = random_q - 1'b1;
  end

  // Counter and Wired state
  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= TOP;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random = random_q;
  assign wired  = wired_q;

endmodule

// File: rtl/cp0_tlb_ctrl.sv
// CP0 TLB register set, TLB instruction sequencer and exception address capture.
// Handshake: a request is accepted on the edge where tlb_op_valid && tlb_op_ready;
// valid while not ready is ignored, so the requester holds valid until accepted.
module cp0_tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int TLB_LINE  = 32,
  parameter int TLB_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic        tlb_op_valid,
  input  logic [1:0]  tlb_op,
  output logic        tlb_op_ready,
  output logic        tlb_op_done,
  input  logic        tlb_exc,
  input  logic [31:0] exc_vaddr,
  output logic [31:0] mmu_pagemask,
  output logic [31:0] mmu_entrylo0,
  output logic [31:0] mmu_entrylo1,
  output logic [31:0] mmu_entryhi,
  output logic [31:0] mmu_index,
  output logic [31:0] mmu_random,
  output logic        mmu_tlbp,
  output logic        mmu_tlbr,
  output logic        mmu_tlbwi,
  output logic        mmu_tlbwr,
  input  logic [31:0] mmu_pagemask_i,
  input  logic [31:0] mmu_entrylo0_i,
  input  logic [31:0] mmu_entrylo1_i,
  input  logic [31:0] mmu_entryhi_i,
  input  logic [31:0] mmu_index_i,
  output logic [1:0]  dbg_state_o
);

  localparam logic [31:0] IDX_WMASK = low_mask(TLB_WIDTH);

  tlb_state_e state_q;
  tlb_op_e    op_q;
  logic       ready_q, done_q;
  logic       tlbp_q, tlbr_q, tlbwi_q, tlbwr_q;

  logic [31:0] index_q, index_d;
  logic [31:0] entrylo0_q, entrylo0_d;
  logic [31:0] entrylo1_q, entrylo1_d;
  logic [31:0] context_q, context_d;
  logic [31:0] pagemask_q, pagemask_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] entryhi_q, entryhi_d;

  logic                 wired_we;
  logic [TLB_WIDTH-1:0] random, wired;

  assign wired_we = cp0_we && (cp0_waddr == CP0_WIRED);

  tlb_random_ctr #(.TLB_LINE(TLB_LINE), .TLB_WIDTH(TLB_WIDTH)) u_random (
    .clk         (clk),
    .rst         (rst),
    .wired_we    (wired_we),
    .wired_wdata (cp0_wdata[TLB_WIDTH-1:0]),
    .random      (random),
    .wired       (wired)
  );

  // Next register values: mtc0 first, then TLB capture, then exception, so later wins per bit
  always_comb begin
    index_d    = index_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    context_d  = context_q;
    pagemask_d = pagemask_q;
    badvaddr_d = badvaddr_q;
    entryhi_d  = entryhi_q;
    if (cp0_we) begin
      case (cp0_waddr)
        CP0_INDEX:    index_d    = (index_q & ~IDX_WMASK) | (cp0_wdata & IDX_WMASK);
        CP0_ENTRYLO0: entrylo0_d = cp0_wdata & ENTRYLO_WMASK;
        CP0_ENTRYLO1: entrylo1_d = cp0_wdata & ENTRYLO_WMASK;
        CP0_CONTEXT:  context_d  = (context_q & ~CONTEXT_WMASK) | (cp0_wdata & CONTEXT_WMASK);
        CP0_PAGEMASK: pagemask_d = cp0_wdata & PAGEMASK_WMASK;
        CP0_ENTRYHI:  entryhi_d  = cp0_wdata & ENTRYHI_WMASK;
        default: ;
      endcase
    end
    if (state_q == ISSUE) begin
      case (op_q)
        TLBP: index_d = mmu_index_i[31] ? INDEX_P_BIT : (mmu_index_i & IDX_WMASK);
        TLBR: begin
          entryhi_d  = mmu_entryhi_i & ENTRYHI_WMASK;
          entrylo0_d = mmu_entrylo0_i & ENTRYLO_WMASK;
          entrylo1_d = mmu_entrylo1_i & ENTRYLO_WMASK;
          pagemask_d = mmu_pagemask_i & PAGEMASK_WMASK;
        end
        default: ;
      endcase
    end
    if (tlb_exc) begin
      badvaddr_d           = exc_vaddr;
      entryhi_d[31:13]     = exc_vaddr[31:13];
      context_d[22:4]      = exc_vaddr[31:13];
    end
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      context_q  <= '0;
      pagemask_q <= '0;
      badvaddr_q <= '0;
      entryhi_q  <= '0;
    end else begin
      index_q    <= index_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      context_q  <= context_d;
      pagemask_q <= pagemask_d;
      badvaddr_q <= badvaddr_d;
      entryhi_q  <= entryhi_d;
    end
  end

  // TLB instruction sequencer: IDLE -> ISSUE (one strobe) -> DONE (done pulse)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= TLBP;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      tlbp_q  <= 1'b0;
      tlbr_q  <= 1'b0;
      tlbwi_q <= 1'b0;
      tlbwr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tlb_op_valid) begin
            op_q    <= tlb_op_e'(tlb_op);
            state_q <= ISSUE;
            ready_q <= 1'b0;
            tlbp_q  <= (tlb_op_e'(tlb_op) == TLBP);
            tlbr_q  <= (tlb_op_e'(tlb_op) == TLBR);
            tlbwi_q <= (tlb_op_e'(tlb_op) == TLBWI);
            tlbwr_q <= (tlb_op_e'(tlb_op) == TLBWR);
          end
        end
        ISSUE: begin
          tlbp_q  <= 1'b0;
          tlbr_q  <= 1'b0;
          tlbwi_q <= 1'b0;
          tlbwr_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // mfc0 read mux, showing pre-edge register state
  always_comb begin
    case (cp0_raddr)
      CP0_INDEX:    cp0_rdata = index_q;
      CP0_RANDOM:   cp0_rdata = {{(32-TLB_WIDTH){1'b0}}, random};
      CP0_ENTRYLO0: cp0_rdata = entrylo0_q;
      CP0_ENTRYLO1: cp0_rdata = entrylo1_q;
      CP0_CONTEXT:  cp0_rdata = context_q;
      CP0_PAGEMASK: cp0_rdata = pagemask_q;
      CP0_WIRED:    cp0_rdata = {{(32-TLB_WIDTH){1'b0}}, wired};
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_ENTRYHI:  cp0_rdata = entryhi_q;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  assign tlb_op_ready = ready_q;
  assign tlb_op_done  = done_q;
  assign mmu_tlbp     = tlbp_q;
  assign mmu_tlbr     = tlbr_q;
  assign mmu_tlbwi    = tlbwi_q;
  assign mmu_tlbwr    = tlbwr_q;
  assign mmu_index    = index_q;
  assign mmu_random   = {{(32-TLB_WIDTH){1'b0}}, random};
  assign mmu_entrylo0 = entrylo0_q;
  assign mmu_entrylo1 = entrylo1_q;
  assign mmu_entryhi  = entryhi_q;
  assign mmu_pagemask = pagemask_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_cp0_tlb_ctrl.sv
// Self-checking bench for cp0_tlb_ctrl: directed checks plus randomized traffic
// compared against a cycle-level reference model of the CP0 TLB registers.
module tb_cp0_tlb_ctrl;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int LINE = 32;

  logic        clk, rst;
  logic        cp0_we;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic        tlb_op_valid;
  logic [1:0]  tlb_op;
  logic        tlb_op_ready, tlb_op_done;
  logic        tlb_exc;
  logic [31:0] exc_vaddr;
  logic [31:0] mmu_pagemask, mmu_entrylo0, mmu_entrylo1, mmu_entryhi, mmu_index, mmu_random;
  logic        mmu_tlbp, mmu_tlbr, mmu_tlbwi, mmu_tlbwr;
  logic [31:0] mmu_pagemask_i, mmu_entrylo0_i, mmu_entrylo1_i, mmu_entryhi_i, mmu_index_i;
  logic [1:0]  dbg_state;

  cp0_tlb_ctrl dut (
    .clk(clk), .rst(rst),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
    .tlb_op_valid(tlb_op_valid), .tlb_op(tlb_op),
    .tlb_op_ready(tlb_op_ready), .tlb_op_done(tlb_op_done),
    .tlb_exc(tlb_exc), .exc_vaddr(exc_vaddr),
    .mmu_pagemask(mmu_pagemask), .mmu_entrylo0(mmu_entrylo0), .mmu_entrylo1(mmu_entrylo1),
    .mmu_entryhi(mmu_entryhi), .mmu_index(mmu_index), .mmu_random(mmu_random),
    .mmu_tlbp(mmu_tlbp), .mmu_tlbr(mmu_tlbr), .mmu_tlbwi(mmu_tlbwi), .mmu_tlbwr(mmu_tlbwr),
    .mmu_pagemask_i(mmu_pagemask_i), .mmu_entrylo0_i(mmu_entrylo0_i),
    .mmu_entrylo1_i(mmu_entrylo1_i), .mmu_entryhi_i(mmu_entryhi_i),
    .mmu_index_i(mmu_index_i),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_index, m_lo0, m_lo1, m_ctx, m_pm, m_wired, m_bad, m_hi;
  int          m_random;
  int          m_phase;   // 0 waiting, 1 strobe cycle, 2 done cycle
  int          m_op;
  bit          chk_en = 1'b0;
  logic [3:0]  exp_q[$];  // expected strobe vectors in acceptance order

  function automatic logic [31:0] model_read(input int r);
    case (r)
      0:  return m_index;
      1:  return 32'(m_random);
      2:  return m_lo0;
      3:  return m_lo1;
      4:  return m_ctx;
      5:  return m_pm;
      6:  return m_wired;
      8:  return m_bad;
      10: return m_hi;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] n_index, n_lo0, n_lo1, n_ctx, n_pm, n_wired, n_bad, n_hi;
    int n_random;
    if (rst) begin
      m_index = 0; m_lo0 = 0; m_lo1 = 0; m_ctx = 0; m_pm = 0;
      m_wired = 0; m_bad = 0; m_hi = 0;
      m_random = LINE - 1;
      m_phase = 0; m_op = 0;
      exp_q.delete();
      return;
    end
    if (cp0_we && cp0_waddr == 5'd6)   n_random = LINE - 1;
    else if (m_wired >= LINE - 1)      n_random = LINE - 1;
    else if (m_random == int'(m_wired)) n_random = LINE - 1;
    else                               n_random = m_random - 1;
    n_index = m_index; n_lo0 = m_lo0; n_lo1 = m_lo1; n_ctx = m_ctx;
    n_pm = m_pm; n_wired = m_wired; n_bad = m_bad; n_hi = m_hi;
    if (cp0_we) begin
      case (cp0_waddr)
        5'd0:  n_index = (m_index & 32'h8000_0000) | (cp0_wdata & 32'h1F);
        5'd2:  n_lo0 = cp0_wdata & 32'h3FFF_FFFF;
        5'd3:  n_lo1 = cp0_wdata & 32'h3FFF_FFFF;
        5'd4:  n_ctx = (m_ctx & 32'h007F_FFF0) | (cp0_wdata & 32'hFF80_0000);
        5'd5:  n_pm = cp0_wdata & 32'h1FFF_E000;
        5'd6:  n_wired = cp0_wdata & 32'h1F;
        5'd10: n_hi = cp0_wdata & 32'hFFFF_E0FF;
        default: ;
      endcase
    end
    if (m_phase == 1 && m_op == 0)
      n_index = mmu_index_i[31] ? 32'h8000_0000 : (mmu_index_i % 32);
    if (m_phase == 1 && m_op == 1) begin
      n_hi  = mmu_entryhi_i & 32'hFFFF_E0FF;
      n_lo0 = mmu_entrylo0_i & 32'h3FFF_FFFF;
      n_lo1 = mmu_entrylo1_i & 32'h3FFF_FFFF;
      n_pm  = mmu_pagemask_i & 32'h1FFF_E000;
    end
    if (tlb_exc) begin
      n_bad = exc_vaddr;
      n_hi  = (n_hi % 8192) + (exc_vaddr & 32'hFFFF_E000);
      n_ctx = (n_ctx & 32'hFF80_000F) | ((exc_vaddr >> 13) << 4);
    end
    m_index = n_index; m_lo0 = n_lo0; m_lo1 = n_lo1; m_ctx = n_ctx;
    m_pm = n_pm; m_wired = n_wired; m_bad = n_bad; m_hi = n_hi;
    m_random = n_random;
    case (m_phase)
      0: if (tlb_op_valid) begin
           m_phase = 1;
           m_op = int'(tlb_op);
           exp_q.push_back(4'b0001 << tlb_op);
         end
      1: m_phase = 2;
      default: m_phase = 0;
    endcase
  endtask

  always @(posedge clk) model_step();

  // Compare registered outputs against the model every cycle, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] dut_s, mod_s;
      dut_s = {mmu_tlbwr, mmu_tlbwi, mmu_tlbr, mmu_tlbp};
      mod_s = (m_phase == 1) ? (4'b0001 << m_op) : 4'b0000;
      check_eq("ready", 32'(tlb_op_ready), 32'(m_phase == 0));
      check_eq("done", 32'(tlb_op_done), 32'(m_phase == 2));
      check_eq("strobes", 32'(dut_s), 32'(mod_s));
      check_eq("mmu_index", mmu_index, m_index);
      check_eq("mmu_random", mmu_random, 32'(m_random));
      check_eq("mmu_entrylo0", mmu_entrylo0, m_lo0);
      check_eq("mmu_entrylo1", mmu_entrylo1, m_lo1);
      check_eq("mmu_entryhi", mmu_entryhi, m_hi);
      check_eq("mmu_pagemask", mmu_pagemask, m_pm);
      if (dut_s != 4'b0000) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected_strobe", 32'(dut_s), 32'h0);
        else check_eq("sb_strobe_order", 32'(dut_s), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string tag);
    cp0_raddr = addr;
    #0.2;
    check_eq(tag, cp0_rdata, exp);
  endtask

  task automatic rd_model(input logic [4:0] addr);
    cp0_raddr = addr;
    #0.2;
    check_eq("rdata_rand", cp0_rdata, model_read(int'(addr)));
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    cp0_we = 1'b1; cp0_waddr = addr; cp0_wdata = data;
    step();
    cp0_we = 1'b0;
  endtask

  // Waits (bounded) for ready, presents the request, returns in the strobe cycle
  task automatic tlb_req(input logic [1:0] op);
    int n = 0;
    while (!tlb_op_ready && n < 16) begin
      step();
      n++;
    end
    check_eq("req_ready", 32'(tlb_op_ready), 32'h1);
    tlb_op_valid = 1'b1; tlb_op = op;
    step();
    tlb_op_valid = 1'b0;
  endtask

  // Full operation with literal latency checks; optional mtc0 during the strobe cycle
  task automatic run_op(input logic [1:0] op, input logic [3:0] exp_s, input bit issue_we,
                        input logic [4:0] issue_addr, input logic [31:0] issue_data);
    tlb_req(op);
    check_eq("issue_strobe", 32'({mmu_tlbwr, mmu_tlbwi, mmu_tlbr, mmu_tlbp}), 32'(exp_s));
    check_eq("issue_ready", 32'(tlb_op_ready), 32'h0);
    if (issue_we) mtc0(issue_addr, issue_data);
    else step();
    check_eq("done_strobe", 32'({mmu_tlbwr, mmu_tlbwi, mmu_tlbr, mmu_tlbp}), 32'h0);
    check_eq("done_pulse", 32'(tlb_op_done), 32'h1);
    step();
    check_eq("idle_done", 32'(tlb_op_done), 32'h0);
    check_eq("idle_ready", 32'(tlb_op_ready), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rmin;
    bit hit;
    logic [31:0] v;
    rst = 1'b1; cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0; cp0_raddr = 0;
    tlb_op_valid = 0; tlb_op = 0; tlb_exc = 0; exc_vaddr = 0;
    mmu_pagemask_i = 0; mmu_entrylo0_i = 0; mmu_entrylo1_i = 0;
    mmu_entryhi_i = 0; mmu_index_i = 0;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    rd(0, 32'h0, "rst_index");
    rd(1, 32'd31, "rst_random");
    rd(2, 32'h0, "rst_entrylo0");
    rd(3, 32'h0, "rst_entrylo1");
    rd(4, 32'h0, "rst_context");
    rd(5, 32'h0, "rst_pagemask");
    rd(6, 32'h0, "rst_wired");
    rd(8, 32'h0, "rst_badvaddr");
    rd(10, 32'h0, "rst_entryhi");
    check_eq("rst_ready", 32'(tlb_op_ready), 32'h1);
    repeat (5) step();
    rd(1, 32'd26, "random_after_5");

    // Wired reload and wrap
    mtc0(5'd6, 32'd8);
    rd(1, 32'd31, "random_wired_write");
    rmin = 31; hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      step();
      cp0_raddr = 5'd1;
      #0.2;
      v = cp0_rdata;
      if (int'(v) < rmin) rmin = int'(v);
      if (v == 32'd8) hit = 1;
    end
    check_eq("random_reached_wired", 32'(hit), 32'h1);
    check_eq("random_min", 32'(rmin), 32'd8);
    step();
    rd(1, 32'd31, "random_wrap");

    // Write masks
    mtc0(5'd10, 32'hFFFF_FFFF);
    rd(10, 32'hFFFF_E0FF, "mask_entryhi");
    mtc0(5'd2, 32'hFFFF_FFFF);
    rd(2, 32'h3FFF_FFFF, "mask_entrylo0");
    mtc0(5'd0, 32'hFFFF_FFFF);
    rd(0, 32'h0000_001F, "mask_index");
    mtc0(5'd7, 32'hFFFF_FFFF);
    rd(7, 32'h0, "unmapped_reg");

    // TLBP miss then hit
    mmu_index_i = 32'h8000_0000;
    run_op(2'd0, 4'b0001, 1'b0, 5'd0, 32'h0);
    rd(0, 32'h8000_0000, "tlbp_miss_index");
    mmu_index_i = 32'd7;
    run_op(2'd0, 4'b0001, 1'b0, 5'd0, 32'h0);
    rd(0, 32'd7, "tlbp_hit_index");

    // TLBR capture beats a same-cycle mtc0 EntryHi
    mmu_entryhi_i = 32'h1234_50AB; mmu_pagemask_i = 32'hFFFF_FFFF;
    mmu_entrylo0_i = 32'hFFFF_FFFF; mmu_entrylo1_i = 32'h4000_0001;
    run_op(2'd1, 4'b0010, 1'b1, 5'd10, 32'h0);
    rd(10, 32'h1234_40AB, "tlbr_entryhi");
    rd(5, 32'h1FFF_E000, "tlbr_pagemask");
    rd(2, 32'h3FFF_FFFF, "tlbr_entrylo0");
    rd(3, 32'h0000_0001, "tlbr_entrylo1");

    // Exception capture keeps ASID
    mtc0(5'd10, 32'h0000_005A);
    tlb_exc = 1'b1; exc_vaddr = 32'hC000_3ABC;
    step();
    tlb_exc = 1'b0;
    rd(8, 32'hC000_3ABC, "exc_badvaddr");
    rd(10, 32'hC000_205A, "exc_entryhi");
    rd(4, 32'h0060_0010, "exc_context");

    // Exception and mtc0 EntryHi in the same cycle: VPN2 from exc, ASID from mtc0
    tlb_exc = 1'b1; exc_vaddr = 32'h0000_4000;
    mtc0(5'd10, 32'hFFFF_FF77);
    tlb_exc = 1'b0;
    rd(10, 32'h0000_4077, "exc_vs_mtc0");

    // Reset during the strobe cycle
    tlb_req(2'd2);
    check_eq("rst_issue_strobe", 32'(mmu_tlbwi), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_strobes", 32'({mmu_tlbwr, mmu_tlbwi, mmu_tlbr, mmu_tlbp}), 32'h0);
    check_eq("rst_mid_done", 32'(tlb_op_done), 32'h0);
    check_eq("rst_mid_ready", 32'(tlb_op_ready), 32'h1);
    rd(1, 32'd31, "rst_mid_random");
    rd(10, 32'h0, "rst_mid_entryhi");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      cp0_we         = ($urandom_range(0, 2) == 0);
      cp0_waddr      = 5'($urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) cp0_waddr = 5'($urandom_range(0, 31));
      cp0_wdata      = $urandom;
      if (cp0_waddr == 5'd6) cp0_wdata = 32'($urandom_range(0, 33));
      tlb_op_valid   = 1'($urandom_range(0, 1));
      tlb_op         = 2'($urandom_range(0, 3));
      tlb_exc        = ($urandom_range(0, 15) == 0);
      exc_vaddr      = $urandom;
      mmu_index_i    = $urandom;
      mmu_entryhi_i  = $urandom;
      mmu_entrylo0_i = $urandom;
      mmu_entrylo1_i = $urandom;
      mmu_pagemask_i = $urandom;
      rd_model(5'($urandom_range(0, 15)));
      step();
    end

    // Drain
    rst = 0; cp0_we = 0; tlb_op_valid = 0; tlb_exc = 0;
    repeat (4) step();
    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_tlb_ctrl.md
Name: cp0_tlb_ctrl

Overview:
- CP0-side owner of the MIPS TLB register set: Index, Random, EntryLo0, EntryLo1, Context, PageMask, Wired, BadVAddr, EntryHi.
- Drives the cp0 inputs and TLB instruction strobes of the MMU.
- Sequences TLBP/TLBR/TLBWI/TLBWR via a 3-state FSM and writes MMU results back into the registers.
- Captures the faulting address on TLB exceptions.
- Sits between the MEM-stage CP0 access path and the MMU.

Parameters:
TLB_LINE, 32, number of TLB entries
TLB_WIDTH, 5, index width, equal to log2(TLB_LINE)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cp0_we  in  1  mtc0 write enable
cp0_waddr  in  5  mtc0 register number
cp0_wdata  in  32  mtc0 data
cp0_raddr  in  5  mfc0 register number
cp0_rdata  out  32  mfc0 data, combinational
tlb_op_valid  in  1  TLB instruction request
tlb_op  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR
tlb_op_ready  out  1  FSM idle; request accepted when valid&ready
tlb_op_done  out  1  one-cycle completion pulse
tlb_exc  in  1  TLB refill/invalid/modified exception pulse
exc_vaddr  in  32  faulting virtual address
mmu_pagemask, mmu_entrylo0, mmu_entrylo1, mmu_entryhi, mmu_index, mmu_random  out  32 each  register values to MMU
mmu_tlbp, mmu_tlbr, mmu_tlbwi, mmu_tlbwr  out  1 each  one-cycle strobes
mmu_pagemask_i, mmu_entrylo0_i, mmu_entrylo1_i, mmu_entryhi_i, mmu_index_i  in  32 each  MMU TLBR/TLBP results, combinational during the strobe

Behaviour:
Register numbers and write masks (unwritable bits are read-only):
- Index=0: [TLB_WIDTH-1:0] writable; P bit [31] is hardware-only.
- Random=1: read-only.
- EntryLo0=2, EntryLo1=3: [29:0] writable; [31:30]=0.
- Context=4: PTEBase [31:23] writable; BadVPN2 [22:4] hardware; rest 0.
- PageMask=5: [28:13] writable.
- Wired=6: [TLB_WIDTH-1:0] writable.
- BadVAddr=8: read-only.
- EntryHi=10: [31:13] and [7:0] writable.
- Other numbers read 0; writes to them are ignored.

Reset values:
- All registers 0, except Random = TLB_LINE-1.
- FSM in IDLE; tlb_op_ready=1; all strobes and tlb_op_done = 0.

Random:
- Decrements every cycle.
- If Random==Wired, next value is TLB_LINE-1.
- If Wired>=TLB_LINE-1, Random holds TLB_LINE-1.
- An mtc0 to Wired forces Random=TLB_LINE-1 on the next edge, overriding the decrement.

FSM:
- IDLE: ready=1. valid&ready latches tlb_op, then go to ISSUE.
- ISSUE: exactly one strobe high for one cycle; ready=0.
  - TLBR: at the end of this cycle, capture mmu_*_i into EntryHi, EntryLo0, EntryLo1, PageMask, with write masks applied.
  - TLBP: if mmu_index_i[31]=1, Index <= 32'h8000_0000; else Index <= {1'b0, zeros, mmu_index_i[TLB_WIDTH-1:0]}.
  - TLBWI/TLBWR: no capture; the MMU writes at this edge using mmu_index/mmu_random.
  - Always go to DONE.
- DONE: tlb_op_done=1 for one cycle, then go to IDLE.
- Latency: accept edge, then strobe cycle, then done cycle. Next accept is possible in the cycle after DONE.

Exception capture (tlb_exc):
- BadVAddr <= exc_vaddr.
- EntryHi[31:13] <= exc_vaddr[31:13]; ASID is unchanged.
- Context[22:4] <= exc_vaddr[31:13].

Same-cycle write priority per register bit: tlb_exc > FSM capture > mtc0. Lower-priority writes to untouched bits still apply.

Other rules:
- mmu_* outputs are the current register values; writes become visible the cycle after the edge.
- cp0_rdata reflects the register state before any same-cycle write.
- tlb_op_valid while not ready is ignored; the requester must hold it.
- rst mid-operation returns the FSM to IDLE, drops strobes and done, and restores register reset values.

Decomposition:
- Package tlb_ctrl_pkg holds:
  - enum tlb_op_e {TLBP, TLBR, TLBWI, TLBWR};
  - FSM state enum {IDLE, ISSUE, DONE};
  - CP0 register-number localparams (CP0_INDEX=0 ... CP0_ENTRYHI=10);
  - write-mask localparams per register.
- One sub-module, tlb_random_ctr: the Random/Wired counter with wired_we, wired_wdata and random output.

Test Plan:
- Reset, then read all registers -> Random=31, all others 0; ready=1. After 5 cycles Random=26.
- mtc0 Wired=8 -> next cycle Random=31. Run until Random==8; next cycle Random=31 (never <8).
- Write EntryHi=0xFFFF_FFFF -> reads 0xFFFF_E0FF. Write EntryLo0=0xFFFF_FFFF -> reads 0x3FFF_FFFF.
- TLBP request with mmu_index_i=0x8000_0000 -> mmu_tlbp high exactly 1 cycle, Index=0x8000_0000, done on the next cycle. Repeat with mmu_index_i=7 -> Index=7.
- TLBR with mmu_entryhi_i=0x1234_50AB and mmu_pagemask_i=0xFFFF_FFFF -> EntryHi=0x1234_40AB, PageMask=0x1FFF_E000. An mtc0 EntryHi=0 in the same ISSUE cycle loses.
- tlb_exc with exc_vaddr=0xC000_3ABC while EntryHi ASID=0x5A -> BadVAddr=0xC000_3ABC, EntryHi=0xC000_205A, Context[22:4]=0x60001. rst asserted during ISSUE -> strobe and done cleared next cycle.
